mips_cpu_run_controller: RTL

Synthesisable run controller for one or more Harvard MIPS CPU instances, moving the reset/run/timeout sequencing out of the simulation bench and into RTL. It sits between a host or bench `start` strobe and N CPU cores. It drives each core's `reset` and `clk_enable`, watches each core's `active`, and captures `register_v0` at halt. It reports pass, timeout or failed-start status with a cycle count, so the same sequencing serves FPGA bring-up and simulation.

---
 rtl/mips_run_ctrl_pkg.sv | 19 +
 rtl/mips_run_chan.sv | 36 +++
 rtl/mips_cpu_run_controller.sv | 117 +++++++++++
 3 files changed

// File: rtl/mips_run_ctrl_pkg.sv
// Shared state encoding and status codes for the MIPS CPU run controller.
package mips_run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_CHECK,
    S_RUN,
    S_PASS,
    S_TIMEOUT,
    S_NOSTART
  } run_state_t;

  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_PASS    = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;
  localparam logic [1:0] ST_NOSTART = 2'd3;

endpackage

// File: rtl/mips_run_chan.sv
// Per-core channel: halt flag, $v0 capture and registered clock-enable gating.
module mips_run_chan (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        run,
  input  logic        pause,
  input  logic        en,
  input  logic        active,
  input  logic [31:0] register_v0,
  output logic        halted,
  output logic        halted_nxt,
  output logic        clk_enable,
  output logic [31:0] v0_capture
);

  logic hit;

  // First edge in RUN where the core reports inactive; suppressed while paused.
  assign hit        = run & ~pause & ~active & ~halted;
  assign halted_nxt = ~clear & (halted | hit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted     <= 1'b0;
      clk_enable <= 1'b0;
      v0_capture <= '0;
    end else begin
      halted     <= halted_nxt;
      clk_enable <= en & ~halted_nxt & ~(run & pause);
      if (clear)    v0_capture <= '0;
      else if (hit) v0_capture <= register_v0;
    end
  end

endmodule

// File: rtl/mips_cpu_run_controller.sv
// Reset/check/run/timeout sequencer for N lockstep MIPS cores.
// Optional RUN_CTRL_PAUSE_EN adds a pause input that stalls the RUN phase.
module mips_cpu_run_controller
  import mips_run_ctrl_pkg::*;
#(
  parameter int N_CPU          = 1,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int RESET_CYCLES   = 1,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef RUN_CTRL_PAUSE_EN
  input  logic                 pause,
`endif
  output logic                 cpu_reset,
  output logic [N_CPU-1:0]     clk_enable,
  input  logic [N_CPU-1:0]     active,
  input  logic [32*N_CPU-1:0]  register_v0,
  output logic [32*N_CPU-1:0]  v0_capture,
  output logic [N_CPU-1:0]     halted,
  output logic                 busy,
  output logic [1:0]           status,
  output logic [CNT_W-1:0]     cycle_count
);

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_t       state, nxt;
  logic [RC_W-1:0]  rcnt;
  logic [1:0]       status_nxt;
  logic             clear, run, en, pause_w;
  logic [N_CPU-1:0] halted_nxt;

`ifdef RUN_CTRL_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign run = (state == S_RUN);
  assign en  = (nxt == S_RESET) || (nxt == S_CHECK) || (nxt == S_RUN);

  always_comb begin
    nxt        = state;
    status_nxt = status;
    clear      = 1'b0;
    case (state)
      S_IDLE, S_PASS, S_TIMEOUT, S_NOSTART:
        if (start) begin
          nxt        = S_RESET;
          status_nxt = ST_NONE;
          clear      = 1'b1;
        end
      S_RESET:
        if (rcnt == RC_W'(RESET_CYCLES - 1)) nxt = S_CHECK;
      S_CHECK:
        if (&active) nxt = S_RUN;
        else begin
          nxt        = S_NOSTART;
          status_nxt = ST_NOSTART;
        end
      S_RUN:
        // Completion is tested first so a halt on the timeout edge still passes.
        if (&halted_nxt) begin
          nxt        = S_PASS;
          status_nxt = ST_PASS;
        end else if (!pause_w && cycle_count == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          nxt        = S_TIMEOUT;
          status_nxt = ST_TIMEOUT;
        end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      rcnt        <= '0;
      cycle_count <= '0;
      status      <= ST_NONE;
      cpu_reset   <= 1'b1;
      busy        <= 1'b0;
    end else begin
      state     <= nxt;
      status    <= status_nxt;
      cpu_reset <= (nxt == S_IDLE) || (nxt == S_RESET);
      busy      <= en;
      if (clear)                rcnt <= '0;
      else if (state == S_RESET) rcnt <= rcnt + RC_W'(1);
      if (clear)
        cycle_count <= '0;
      else if ((state == S_CHECK || (run && !pause_w)) &&
               cycle_count != CNT_W'(TIMEOUT_CYCLES))
        cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < N_CPU; i++) begin : g_chan
    mips_run_chan u_chan (
      .clk         (clk),
      .rst         (reset),
      .clear       (clear),
      .run         (run),
      .pause       (pause_w),
      .en          (en),
      .active      (active[i]),
      .register_v0 (register_v0[32*i +: 32]),
      .halted      (halted[i]),
      .halted_nxt  (halted_nxt[i]),
      .clk_enable  (clk_enable[i]),
      .v0_capture  (v0_capture[32*i +: 32])
    );
  end

endmodule
